// File: rtl/shift_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_buf_pkg
// Description : Shared defaults and helpers for the shift-buffer stream
//               controller (word width, delay depth, counter widths).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_buf_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 256;
    localparam int STAT_W    = 32;

    // Width of a counter that must be able to hold the value 'depth'
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : shift_buf_pkg
`default_nettype wire

// File: rtl/shift_buf_stream_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Parameterised up-counter that stops at MAX. Synchronous
//               clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up until MAX is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/shift_buf_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_buf_stream_ctrl
// Description : Valid/ready front end for an external shift RAM of delay
//               DEPTH. Each accepted input word becomes one ce-qualified
//               push; the delayed RAM output is presented as a valid/ready
//               stream once DEPTH pushes have primed the line. Downstream
//               backpressure stalls pushes so no delayed word is lost.
//               Optional macro SHIFT_BUF_STATS_EN adds push/pop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_buf_stream_ctrl
    import shift_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              in_ready_o,
    output logic              ram_ce_o,
    output logic [WIDTH-1:0]  ram_d_o,
    input  logic [WIDTH-1:0]  ram_q_i,
    output logic              out_valid_o,
    output logic [WIDTH-1:0]  out_data_o,
    input  logic              out_ready_i,
`ifdef SHIFT_BUF_STATS_EN
    output logic [STAT_W-1:0] stat_in_cnt_o,
    output logic [STAT_W-1:0] stat_out_cnt_o,
`endif
    output logic              primed_o
);

    localparam int           CW      = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          w_push;
    logic          w_primed;
    logic [CW-1:0] fill_cnt_q;
    logic          out_valid_q;
    logic          out_valid_d;

    // Once primed, a push overwrites the word on ram_q, so it is only
    // allowed when the output slot is empty or being drained this cycle.
    assign in_ready_o = !flush_i && (!w_primed || !out_valid_q || out_ready_i);
    assign w_push     = in_valid_i && in_ready_o;
    assign ram_ce_o   = w_push;
    assign ram_d_o    = in_data_i;
    assign out_data_o = ram_q_i;

    // Pushes since reset/flush, stopping at DEPTH (line primed)
    sat_counter #(
        .W   (CW),
        .MAX (DEPTH_C)
    ) u_fill_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (w_push),
        .cnt_o  (fill_cnt_q)
    );

    assign w_primed = (fill_cnt_q == DEPTH_C);
    assign primed_o = w_primed;

    // Output slot: filled by a primed push, emptied by flush or consumption
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (w_push && w_primed) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output-valid register; reset drops it immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;

`ifdef SHIFT_BUF_STATS_EN
    logic w_pop;
    assign w_pop = out_valid_q && out_ready_i;

    // Lifetime push count; survives flush
    sat_counter #(
        .W   (STAT_W),
        .MAX ({STAT_W{1'b1}})
    ) u_stat_in (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (w_push),
        .cnt_o  (stat_in_cnt_o)
    );

    // Lifetime delivered-word count; survives flush
    sat_counter #(
        .W   (STAT_W),
        .MAX ({STAT_W{1'b1}})
    ) u_stat_out (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (w_pop),
        .cnt_o  (stat_out_cnt_o)
    );
`endif

endmodule : shift_buf_stream_ctrl
`default_nettype wire

// File: tb/tb_shift_buf_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_buf_stream_ctrl
// Description : Self-checking bench for shift_buf_stream_ctrl with DEPTH=4,
//               a queue-based shift RAM model and a push-history reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_buf_stream_ctrl;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         ram_ce;
    logic [W-1:0] ram_d;
    logic [W-1:0] ram_q = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b1;
    logic         primed;
`ifdef SHIFT_BUF_STATS_EN
    logic [31:0]  stat_in_cnt;
    logic [31:0]  stat_out_cnt;
`endif

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_buf_stream_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .ram_ce_o       (ram_ce),
        .ram_d_o        (ram_d),
        .ram_q_i        (ram_q),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .out_ready_i    (out_ready),
`ifdef SHIFT_BUF_STATS_EN
        .stat_in_cnt_o  (stat_in_cnt),
        .stat_out_cnt_o (stat_out_cnt),
`endif
        .primed_o       (primed)
    );

    // Behavioural shift RAM: each push reveals the word pushed D pushes ago
    logic [W-1:0] ram_line[$];
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_line.push_back(ram_d);
            if (ram_line.size() > D) ram_q <= ram_line.pop_front();
        end
    end

    // Reference: full push history plus fill level and output slot
    logic [W-1:0] hist[$];
    int           m_fill = 0;
    bit           m_ov   = 1'b0;
    logic [W-1:0] m_od   = '0;
    int           m_in   = 0;
    int           m_out  = 0;
    logic [W-1:0] outs[$];

    function automatic bit m_ready();
        return !flush && ((m_fill != D) || !m_ov || out_ready);
    endfunction

    always @(negedge rst_n) begin
        m_fill = 0;
        m_ov   = 1'b0;
        m_in   = 0;
        m_out  = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit push;
            bit was_primed;
            push       = in_valid && m_ready();
            was_primed = (m_fill == D);
            if (m_ov && out_ready) begin
                m_out++;
                outs.push_back(out_data);
            end
            if (push) m_in++;
            if (flush) begin
                m_fill = 0;
                m_ov   = 1'b0;
            end else if (push) begin
                hist.push_back(in_data);
                if (was_primed) begin
                    m_ov = 1'b1;
                    m_od = hist[hist.size() - 1 - D];
                end else begin
                    m_fill++;
                    if (out_ready) m_ov = 1'b0;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference, mid-cycle
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready()));
            chk("ram_ce", 64'(ram_ce), 64'(in_valid && m_ready()));
            if (ram_ce) chk("ram_d", 64'(ram_d), 64'(in_data));
            chk("primed", 64'(primed), 64'(m_fill == D));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov) chk("out_data", 64'(out_data), 64'(m_od));
`ifdef SHIFT_BUF_STATS_EN
            chk("stat_in", 64'(stat_in_cnt), 64'(m_in));
            chk("stat_out", 64'(stat_out_cnt), 64'(m_out));
`endif
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_primed", 64'(primed), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ram_ce", 64'(ram_ce), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic priming();
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, W'(100 + i), 1'b1, 1'b0);
            chk("prime_out_valid", 64'(out_valid), 64'd0);
            chk("prime_primed", 64'(primed), 64'(i == D - 1));
        end
        cyc(1'b1, W'(104), 1'b1, 1'b0);
        chk("prime_first_valid", 64'(out_valid), 64'd1);
        chk("prime_first_data", 64'(out_data), 64'd100);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("prime_drain", 64'(out_valid), 64'd0);
    endtask

    initial begin
        @(posedge clk);
        do_reset();
        chk_en = 1'b1;

        // Priming
        priming();

        // Streaming 100..119 from a fresh line
        do_reset();
        outs.delete();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, W'(100 + i), 1'b1, 1'b0);
            chk("stream_no_bubble", 64'(out_valid), 64'(i >= D));
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("stream_count", 64'(outs.size()), 64'd16);
        for (int j = 0; j < outs.size(); j++)
            chk("stream_order", 64'(outs[j]), 64'(100 + j));
`ifdef SHIFT_BUF_STATS_EN
        chk("stat_in_20", 64'(stat_in_cnt), 64'd20);
        chk("stat_out_16", 64'(stat_out_cnt), 64'd16);
`endif

        // Backpressure: line primed, slot filled with 116 and held
        cyc(1'b1, W'(120), 1'b0, 1'b0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", 64'(out_data), 64'd116);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, W'(121), 1'b0, 1'b0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_ram_ce", 64'(ram_ce), 64'd0);
            chk("bp_hold", 64'(out_data), 64'd116);
        end
        cyc(1'b1, W'(121), 1'b1, 1'b0);
        chk("bp_resume", 64'(out_data), 64'd117);
        cyc(1'b1, W'(122), 1'b1, 1'b0);
        chk("bp_next", 64'(out_data), 64'd118);

        // Flush while primed and valid, with a word offered
        in_valid  = 1'b1;
        in_data   = W'(199);
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_ram_ce", 64'(ram_ce), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_primed", 64'(primed), 64'd0);
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, W'(200 + i), 1'b1, 1'b0);
            chk("flush_silent", 64'(out_valid), 64'd0);
        end
        cyc(1'b1, W'(204), 1'b0, 1'b0);
        chk("flush_first_valid", 64'(out_valid), 64'd1);
        chk("flush_first_data", 64'(out_data), 64'd200);

        // Asynchronous reset between edges while a word is presented
        cyc(1'b1, W'(205), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_primed", 64'(primed), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        priming();

        // Randomised traffic with occasional flush
        for (int n = 0; n < 800; n++) begin
            cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_shift_buf_stream_ctrl
`default_nettype wire
